// File: rtl/except_ctrl.sv
// ---------------------------------------------------------------------------
// except_ctrl
//
// Exception / interrupt arbiter in front of the CP0 register file.
//
// One exception is picked per cycle by fixed priority, from the MEM-stage
// flags and the pending-interrupt condition. The pick drives a one-cycle
// registered pulse: excepttype_o, flush_o and new_pc_o. The PC, delay-slot
// flag and (for address/TLB faults) the faulting address are captured with
// the same pulse. While the pipeline refills, further exceptions are ignored
// for HOLD_CYCLES cycles. Interrupt requests that arrive in that window are
// not lost: their level is still visible in cause_i, so they are evaluated
// again once the block is back in IDLE.
//
// External interrupt lines go through a 2-flop synchroniser before CP0 sees
// them. The CP0 timer interrupt is already synchronous, so it is ORed in
// after the synchroniser.
//
// Ports
//   clk                  in   system clock, rising edge
//   rst                  in   asynchronous reset, active low
//   mem_valid_i          in   MEM-stage instruction valid
//   exc_i[10:0]          in   raw flags: [0]INT-eligible [1]ADEL [2]TLBL [3]RI
//                             [4]CPU [5]SYSCALL [6]ERET [7]ADES [8]TLBS
//                             [9]TLBM [10]WATCH
//   current_inst_addr_i  in   PC of the MEM-stage instruction
//   bad_v_addr_i         in   faulting virtual address
//   is_in_delayslot_i    in   MEM instruction sits in a delay slot
//   status_i, cause_i    in   bypassed CP0 Status / Cause
//   epc_i, ebase_i       in   bypassed CP0 EPC / EBase
//   int_raw_i[5:0]       in   asynchronous external interrupt lines
//   timer_int_i          in   CP0 timer interrupt
//   int_o[5:0]           out  synchronised interrupts to CP0 int_i
//   excepttype_o         out  exception code, zero when idle
//   current_inst_addr_o  out  captured PC
//   bad_v_addr_o         out  captured bad address
//   is_in_delayslot_o    out  captured delay-slot flag
//   flush_o              out  one-cycle pipeline flush pulse
//   new_pc_o             out  redirect target, valid while flush_o==1
//   busy_o               out  high in FLUSH and HOLD
// ---------------------------------------------------------------------------
module except_ctrl #(
    parameter logic [11:0] VEC_OFFSET  = 12'h180,
    // Legal range 1..15; the hold counter is 4 bits wide.
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [10:0] exc_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic [31:0] bad_v_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic [5:0]  int_raw_i,
    input  logic        timer_int_i,
    output logic [5:0]  int_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic [31:0] bad_v_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    // -----------------------------------------------------------------------
    // Exception codes presented to CP0 (zero is reserved for "no exception")
    // -----------------------------------------------------------------------
    localparam logic [31:0] EXCEPTION_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXCEPTION_TLBL      = 32'h0000_0002;
    localparam logic [31:0] EXCEPTION_TLBS      = 32'h0000_0003;
    localparam logic [31:0] EXCEPTION_ADEL      = 32'h0000_0004;
    localparam logic [31:0] EXCEPTION_ADES      = 32'h0000_0005;
    localparam logic [31:0] EXCEPTION_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXCEPTION_RI        = 32'h0000_000a;
    localparam logic [31:0] EXCEPTION_CPU       = 32'h0000_000b;
    localparam logic [31:0] EXCEPTION_ERET      = 32'h0000_000e;
    localparam logic [31:0] EXCEPTION_TLBM      = 32'h0000_0011;
    localparam logic [31:0] EXCEPTION_WATCH     = 32'h0000_0017;

    // Flag positions in exc_i
    localparam int EXC_INT     = 0;
    localparam int EXC_ADEL    = 1;
    localparam int EXC_TLBL    = 2;
    localparam int EXC_RI      = 3;
    localparam int EXC_CPU     = 4;
    localparam int EXC_SYSCALL = 5;
    localparam int EXC_ERET    = 6;
    localparam int EXC_ADES    = 7;
    localparam int EXC_TLBS    = 8;
    localparam int EXC_TLBM    = 9;
    localparam int EXC_WATCH   = 10;

    // FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [3:0] HOLD_INIT = HOLD_CYCLES[3:0];

    logic [1:0]  state;
    logic [3:0]  hold_cnt;

    logic [5:0]  int_sync1;
    logic [5:0]  int_sync2;

    logic        int_take;
    logic [10:0] req;

    logic        sel_valid;
    logic [31:0] sel_code;
    logic        sel_bad;   // selected exception carries a faulting address
    logic        sel_eret;

    logic [31:0] vector_pc;
    logic [31:0] target_pc;

    // -----------------------------------------------------------------------
    // Interrupt line synchroniser
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; with blocking assignments
    // int_sync2 would see the new int_sync1 and the two stages would collapse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            int_sync1 <= '0;
            int_sync2 <= '0;
        end else begin
            int_sync1 <= int_raw_i;
            int_sync2 <= int_sync1;
        end
    end

    // The timer is generated inside the clock domain, so it bypasses the
    // synchroniser and reaches CP0 in the same cycle.
    assign int_o = {int_sync2[5] | timer_int_i, int_sync2[4:0]};

    // -----------------------------------------------------------------------
    // Request vector
    // -----------------------------------------------------------------------
    // An interrupt is taken only when interrupts are globally enabled (IE),
    // the core is at normal level (EXL=0, ERL=0) and at least one pending
    // cause bit is unmasked by the matching IM bit.
    assign int_take = mem_valid_i & exc_i[EXC_INT]
                    & status_i[0] & ~status_i[1] & ~status_i[2]
                    & (|(cause_i[15:8] & status_i[15:8]));

    assign req = {exc_i[10:1] & {10{mem_valid_i}}, int_take};

    // -----------------------------------------------------------------------
    // Fixed-priority selection; lower flag index wins
    // -----------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the if-chain so
    // no path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        sel_valid = 1'b1;
        sel_code  = '0;
        sel_bad   = 1'b0;
        sel_eret  = 1'b0;
        if (req[EXC_INT]) begin
            sel_code = EXCEPTION_INTERRUPT;
        end else if (req[EXC_ADEL]) begin
            sel_code = EXCEPTION_ADEL;
            sel_bad  = 1'b1;
        end else if (req[EXC_TLBL]) begin
            sel_code = EXCEPTION_TLBL;
            sel_bad  = 1'b1;
        end else if (req[EXC_RI]) begin
            sel_code = EXCEPTION_RI;
        end else if (req[EXC_CPU]) begin
            sel_code = EXCEPTION_CPU;
        end else if (req[EXC_SYSCALL]) begin
            sel_code = EXCEPTION_SYSCALL;
        end else if (req[EXC_ERET]) begin
            // Reported even with EXL already clear: CP0 clears EXL
            // idempotently, so there is nothing to special-case here.
            sel_code = EXCEPTION_ERET;
            sel_eret = 1'b1;
        end else if (req[EXC_ADES]) begin
            sel_code = EXCEPTION_ADES;
            sel_bad  = 1'b1;
        end else if (req[EXC_TLBS]) begin
            sel_code = EXCEPTION_TLBS;
            sel_bad  = 1'b1;
        end else if (req[EXC_TLBM]) begin
            sel_code = EXCEPTION_TLBM;
            sel_bad  = 1'b1;
        end else if (req[EXC_WATCH]) begin
            sel_code = EXCEPTION_WATCH;
        end else begin
            sel_valid = 1'b0;
        end
    end

    // All exceptions share one vector. The low 12 bits of the base are
    // zeroed, so the 32-bit sum simply wraps and there is no carry out.
    assign vector_pc = {ebase_i[31:12], 12'h000} + {20'h00000, VEC_OFFSET};
    assign target_pc = sel_eret ? epc_i : vector_pc;

    // -----------------------------------------------------------------------
    // Control FSM and registered outputs
    // -----------------------------------------------------------------------
    // NOTE: the asynchronous reset clears every flop here, including the
    // captured PC / bad address, so CP0 never sees stale data after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            hold_cnt            <= '0;
            excepttype_o        <= '0;
            flush_o             <= 1'b0;
            new_pc_o            <= '0;
            current_inst_addr_o <= '0;
            bad_v_addr_o        <= '0;
            is_in_delayslot_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state               <= ST_FLUSH;
                        excepttype_o        <= sel_code;
                        flush_o             <= 1'b1;
                        new_pc_o            <= target_pc;
                        current_inst_addr_o <= current_inst_addr_i;
                        is_in_delayslot_o   <= is_in_delayslot_i;
                        // BadVAddr only changes for address and TLB faults.
                        if (sel_bad) begin
                            bad_v_addr_o <= bad_v_addr_i;
                        end
                    end
                end

                ST_FLUSH: begin
                    // The pulse lasts exactly one cycle.
                    state        <= ST_HOLD;
                    hold_cnt     <= HOLD_INIT;
                    excepttype_o <= '0;
                    flush_o      <= 1'b0;
                    new_pc_o     <= '0;
                end

                ST_HOLD: begin
                    // Leaving on a count of 1 makes HOLD last exactly
                    // HOLD_CYCLES cycles. The <= also covers a corrupted
                    // zero count so the FSM cannot get stuck here.
                    if (hold_cnt <= 4'd1) begin
                        state    <= ST_IDLE;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

    // Input bits this block has no use for; collected here so they are
    // visibly accounted for rather than silently dangling.
    logic unused_inputs;
    assign unused_inputs = ^{status_i[31:16], status_i[7:3],
                             cause_i[31:16], cause_i[7:0], ebase_i[11:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// ---------------------------------------------------------------------------
// tb_except_ctrl
//
// Directed bench for except_ctrl. Expected pulses are pushed to a queue as
// the stimulus is driven and popped one edge later, when the DUT has
// registered its response. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_except_ctrl;

    localparam logic [31:0] EXCEPTION_INTERRUPT = 32'h0000_0001;
    localparam logic [31:0] EXCEPTION_TLBL      = 32'h0000_0002;
    localparam logic [31:0] EXCEPTION_TLBS      = 32'h0000_0003;
    localparam logic [31:0] EXCEPTION_ADEL      = 32'h0000_0004;
    localparam logic [31:0] EXCEPTION_ADES      = 32'h0000_0005;
    localparam logic [31:0] EXCEPTION_SYSCALL   = 32'h0000_0008;
    localparam logic [31:0] EXCEPTION_CPU       = 32'h0000_000b;
    localparam logic [31:0] EXCEPTION_ERET      = 32'h0000_000e;
    localparam logic [31:0] EXCEPTION_TLBM      = 32'h0000_0011;
    localparam logic [31:0] EXCEPTION_WATCH     = 32'h0000_0017;

    localparam logic [10:0] F_INT     = 11'h001;
    localparam logic [10:0] F_ADEL    = 11'h002;
    localparam logic [10:0] F_TLBL    = 11'h004;
    localparam logic [10:0] F_RI      = 11'h008;
    localparam logic [10:0] F_CPU     = 11'h010;
    localparam logic [10:0] F_SYSCALL = 11'h020;
    localparam logic [10:0] F_ERET    = 11'h040;
    localparam logic [10:0] F_ADES    = 11'h080;
    localparam logic [10:0] F_TLBS    = 11'h100;
    localparam logic [10:0] F_TLBM    = 11'h200;
    localparam logic [10:0] F_WATCH   = 11'h400;

    localparam logic [31:0] VEC_PC = 32'h8000_0180;
    localparam logic [31:0] EPC_DEFAULT = 32'h8000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [10:0] exc_i;
    logic [31:0] current_inst_addr_i;
    logic [31:0] bad_v_addr_i;
    logic        is_in_delayslot_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic [31:0] ebase_i;
    logic [5:0]  int_raw_i;
    logic        timer_int_i;
    logic [5:0]  int_o;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic [31:0] bad_v_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    always #5 clk = ~clk;

    except_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .exc_i               (exc_i),
        .current_inst_addr_i (current_inst_addr_i),
        .bad_v_addr_i        (bad_v_addr_i),
        .is_in_delayslot_i   (is_in_delayslot_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .ebase_i             (ebase_i),
        .int_raw_i           (int_raw_i),
        .timer_int_i         (timer_int_i),
        .int_o               (int_o),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .bad_v_addr_o        (bad_v_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .busy_o              (busy_o)
    );

    typedef struct {
        string       tag;
        logic [31:0] etype;
        logic        flush;
        logic [31:0] pc;
        logic        cap;     // also compare captured addr/bad/delayslot
        logic [31:0] addr;
        logic [31:0] bad;
        logic        ds;
    } exp_t;

    typedef struct {
        string       tag;
        logic [10:0] flags;
        logic [31:0] code;
        logic [31:0] pc;
    } prio_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] etype, input logic flush,
                        input logic [31:0] pc, input logic cap, input logic [31:0] addr,
                        input logic [31:0] bad, input logic ds);
        exp_t e;
        e.tag = tag; e.etype = etype; e.flush = flush; e.pc = pc;
        e.cap = cap; e.addr = addr; e.bad = bad; e.ds = ds;
        sb.push_back(e);
    endtask

    task automatic push_idle(input string tag);
        push(tag, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            errors++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_etype"}, excepttype_o, e.etype);
            check({e.tag, "_flush"}, {31'b0, flush_o}, {31'b0, e.flush});
            check({e.tag, "_newpc"}, new_pc_o, e.pc);
            if (e.cap) begin
                check({e.tag, "_addr"}, current_inst_addr_o, e.addr);
                check({e.tag, "_bad"}, bad_v_addr_o, e.bad);
                check({e.tag, "_ds"}, {31'b0, is_in_delayslot_o}, {31'b0, e.ds});
            end
        end
    endtask

    task automatic clear_exc();
        exc_i       = '0;
        mem_valid_i = 1'b0;
    endtask

    // Let FLUSH and HOLD run out after a pulse sampled on the previous tick.
    task automatic drain();
        tick();
        tick();
        tick();
        check("drain_idle", {31'b0, busy_o}, 32'd0);
    endtask

    prio_t prio_tab[7];

    initial begin
        prio_tab[0] = '{"p_adel",  F_ADEL | F_TLBL | F_WATCH,  EXCEPTION_ADEL,  VEC_PC};
        prio_tab[1] = '{"p_cpu",   F_CPU | F_SYSCALL,          EXCEPTION_CPU,   VEC_PC};
        prio_tab[2] = '{"p_eret",  F_ERET | F_ADES | F_TLBS,   EXCEPTION_ERET,  EPC_DEFAULT};
        prio_tab[3] = '{"p_ades",  F_ADES | F_TLBM | F_WATCH,  EXCEPTION_ADES,  VEC_PC};
        prio_tab[4] = '{"p_tlbs",  F_TLBS | F_TLBM,            EXCEPTION_TLBS,  VEC_PC};
        prio_tab[5] = '{"p_tlbm",  F_TLBM | F_WATCH,           EXCEPTION_TLBM,  VEC_PC};
        prio_tab[6] = '{"p_watch", F_WATCH,                    EXCEPTION_WATCH, VEC_PC};

        rst                 = 1'b0;
        mem_valid_i         = 1'b0;
        exc_i               = '0;
        current_inst_addr_i = '0;
        bad_v_addr_i        = '0;
        is_in_delayslot_i   = 1'b0;
        status_i            = '0;
        cause_i             = '0;
        epc_i               = EPC_DEFAULT;
        ebase_i             = 32'h8000_0000;
        int_raw_i           = '0;
        timer_int_i         = 1'b0;

        // Reset state
        #2;
        check("rst_etype", excepttype_o, 32'h0);
        check("rst_flush", {31'b0, flush_o}, 32'd0);
        check("rst_busy",  {31'b0, busy_o}, 32'd0);
        check("rst_int",   {26'b0, int_o}, 32'd0);
        check("rst_newpc", new_pc_o, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // SYSCALL: one-cycle pulse, then FLUSH + 2 HOLD cycles of busy
        mem_valid_i         = 1'b1;
        exc_i               = F_SYSCALL;
        current_inst_addr_i = 32'h8000_1000;
        bad_v_addr_i        = 32'haaaa_0000;
        push("syscall", EXCEPTION_SYSCALL, 1'b1, VEC_PC, 1'b1, 32'h8000_1000, 32'h0, 1'b0);
        tick();
        pop_check();
        check("syscall_busy", {31'b0, busy_o}, 32'd1);
        clear_exc();
        push_idle("syscall_end");
        tick();
        pop_check();
        check("hold_busy", {31'b0, busy_o}, 32'd1);
        tick();
        check("hold2_busy", {31'b0, busy_o}, 32'd1);
        tick();
        check("back_idle", {31'b0, busy_o}, 32'd0);

        // TLBL beats RI; delay slot and bad address captured
        mem_valid_i         = 1'b1;
        exc_i               = F_RI | F_TLBL;
        is_in_delayslot_i   = 1'b1;
        bad_v_addr_i        = 32'h1234_5678;
        current_inst_addr_i = 32'h8000_1004;
        push("tlbl", EXCEPTION_TLBL, 1'b1, VEC_PC, 1'b1, 32'h8000_1004, 32'h1234_5678, 1'b1);
        tick();
        pop_check();
        clear_exc();
        is_in_delayslot_i = 1'b0;
        drain();

        // Priority table
        for (int i = 0; i < 7; i++) begin
            mem_valid_i = 1'b1;
            exc_i       = prio_tab[i].flags;
            push(prio_tab[i].tag, prio_tab[i].code, 1'b1, prio_tab[i].pc,
                 1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            pop_check();
            clear_exc();
            drain();
        end

        // Non-INT flags need mem_valid_i
        exc_i = F_SYSCALL;
        push_idle("novalid");
        tick();
        pop_check();
        clear_exc();

        // Interrupt line synchroniser: two edges to reach int_o
        int_raw_i = 6'b000100;
        tick();
        check("sync_1edge", {26'b0, int_o}, 32'd0);
        tick();
        check("sync_2edge", {26'b0, int_o}, 32'h4);

        // Interrupt taken (IE=1, IM4 & IP4) and beats ADEL
        cause_i             = 32'h0000_1000;
        status_i            = 32'h0000_1001;
        mem_valid_i         = 1'b1;
        exc_i               = F_INT | F_ADEL;
        current_inst_addr_i = 32'h8000_1100;
        push("int", EXCEPTION_INTERRUPT, 1'b1, VEC_PC, 1'b1, 32'h8000_1100, 32'h1234_5678, 1'b0);
        tick();
        pop_check();
        clear_exc();
        drain();

        // EXL set: no interrupt
        status_i    = 32'h0000_1003;
        mem_valid_i = 1'b1;
        exc_i       = F_INT;
        push_idle("int_exl");
        tick();
        pop_check();
        // Pending bit not enabled by IM
        status_i = 32'h0000_0401;
        push_idle("int_masked");
        tick();
        pop_check();
        // No valid instruction
        status_i    = 32'h0000_1001;
        mem_valid_i = 1'b0;
        push_idle("int_novalid");
        tick();
        pop_check();
        clear_exc();
        status_i = '0;
        cause_i  = '0;

        // ERET with EXL clear redirects to EPC and keeps the old bad address
        epc_i               = 32'h8000_2004;
        bad_v_addr_i        = 32'hdead_beef;
        current_inst_addr_i = 32'h8000_2000;
        mem_valid_i         = 1'b1;
        exc_i               = F_ERET;
        push("eret", EXCEPTION_ERET, 1'b1, 32'h8000_2004, 1'b1, 32'h8000_2000, 32'h1234_5678, 1'b0);
        tick();
        pop_check();
        // SYSCALL held through FLUSH and HOLD is ignored, then taken in IDLE
        exc_i = F_SYSCALL;
        push_idle("ign_flush");
        tick();
        pop_check();
        push_idle("ign_hold1");
        tick();
        pop_check();
        push_idle("ign_hold2");
        tick();
        pop_check();
        check("ign_idle_busy", {31'b0, busy_o}, 32'd0);
        push("after_hold", EXCEPTION_SYSCALL, 1'b1, VEC_PC, 1'b1, 32'h8000_2000, 32'h1234_5678, 1'b0);
        tick();
        pop_check();

        // Asynchronous reset in the middle of FLUSH
        rst = 1'b0;
        clear_exc();
        #1;
        check("midrst_flush", {31'b0, flush_o}, 32'd0);
        check("midrst_etype", excepttype_o, 32'h0);
        check("midrst_busy",  {31'b0, busy_o}, 32'd0);
        check("midrst_int",   {26'b0, int_o}, 32'd0);
        check("midrst_bad",   bad_v_addr_o, 32'h0);
        #1;
        rst = 1'b1;
        tick();
        check("rel_1edge_int", {26'b0, int_o}, 32'd0);
        tick();
        check("rel_2edge_int", {26'b0, int_o}, 32'h4);

        // Timer interrupt bypasses the synchroniser
        timer_int_i = 1'b1;
        #1;
        check("timer_rise", {26'b0, int_o}, 32'h24);
        timer_int_i = 1'b0;
        #1;
        check("timer_fall", {26'b0, int_o}, 32'h4);

        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
